// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader sequencer and its bench.
package prog_loader_pkg;

   localparam int DATA_W = 4;
   localparam int DEPTH  = 16;
   localparam int LEN_W  = 5;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PCRST  = 3'd1,
      LOAD   = 3'd2,
      REWIND = 3'd3,
      RUN    = 3'd4
   } state_e;

   // Core ISA opcodes used by the reference program.
   localparam logic [DATA_W-1:0] OP_NOP  = 4'd0;
   localparam logic [DATA_W-1:0] OP_ADD  = 4'd4;
   localparam logic [DATA_W-1:0] OP_SUB  = 4'd5;
   localparam logic [DATA_W-1:0] OP_LDI  = 4'd6;
   localparam logic [DATA_W-1:0] OP_OUT  = 4'd7;
   localparam logic [DATA_W-1:0] OP_JMP  = 4'd8;
   localparam logic [DATA_W-1:0] OP_HALT = 4'd9;

endpackage

// File: rtl/run_timer.sv
// Loadable saturating down-counter; tc_o flags the last counted cycle.
module run_timer #(
   parameter int RUN_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [RUN_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             tc_o
);

   logic [RUN_W-1:0] cnt_q, cnt_d;

   // Load has priority; decrement stops at zero so the count never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   // Count register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   // Terminal count at 1 (or an already-drained 0) ends the run.
   assign tc_o = (cnt_q[RUN_W-1:1] == '0);

endmodule

// File: rtl/prog_loader_seq.sv
// Program-load / run sequencer for the 4-bit core: streams host words into
// program memory, rewinds the PC, runs the core for a set cycle count.
module prog_loader_seq #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 16,
   parameter int RUN_W  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [4:0]        prog_len,
   input  logic [RUN_W-1:0]  run_cycles,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_operand,
   input  logic [DATA_W-1:0] in_opcode,
   output logic              core_PC_reset,
   output logic              core_mem_write,
   output logic              core_hold,
   output logic [DATA_W-1:0] core_portin,
   output logic [DATA_W-1:0] core_instr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [4:0]        load_count
);
   import prog_loader_pkg::*;

   localparam logic [4:0] MAX_LEN = 5'(DEPTH);

   state_e           state_q, state_d;
   logic [4:0]       len_q, len_d;
   logic [RUN_W-1:0] rc_q, rc_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             tmr_load, tmr_dec, tmr_tc;
   logic             len_ok;
   logic [RUN_W-1:0] run_len;

   assign len_ok  = (prog_len != 5'd0) && (prog_len <= MAX_LEN);
   // A zero run length still gives the core one cycle.
   assign run_len = (rc_q == '0) ? RUN_W'(1) : rc_q;

   run_timer #(.RUN_W(RUN_W)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (tmr_load),
      .load_val_i (run_len),
      .dec_i      (tmr_dec),
      .tc_o       (tmr_tc)
   );

   // Next-state and core-facing outputs; abort overrides the next state last.
   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      rc_d           = rc_q;
      cnt_d          = cnt_q;
      done_d         = 1'b0;
      err_d          = 1'b0;
      in_ready       = 1'b0;
      core_PC_reset  = 1'b0;
      core_mem_write = 1'b0;
      core_hold      = 1'b1;
      core_portin    = '0;
      core_instr     = '0;
      tmr_load       = 1'b0;
      tmr_dec        = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               if (len_ok) begin
                  len_d   = prog_len;
                  rc_d    = run_cycles;
                  cnt_d   = 5'd0;
                  state_d = PCRST;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         PCRST: begin
            core_PC_reset = 1'b1;
            core_hold     = 1'b0;
            state_d       = LOAD;
         end
         LOAD: begin
            in_ready       = 1'b1;
            core_mem_write = in_valid;
            core_hold      = ~in_valid;
            core_portin    = in_operand;
            core_instr     = in_opcode;
            if (in_valid) begin
               cnt_d = cnt_q + 5'd1;
               if (cnt_q + 5'd1 == len_q) state_d = REWIND;
            end
         end
         REWIND: begin
            core_PC_reset = 1'b1;
            core_hold     = 1'b0;
            tmr_load      = 1'b1;
            state_d       = RUN;
         end
         RUN: begin
            core_hold = 1'b0;
            tmr_dec   = 1'b1;
            if (tmr_tc) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
   end

   // Sequencer state and latched job parameters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         rc_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         rc_q    <= rc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign err        = err_q;
   assign load_count = cnt_q;

endmodule

// File: tb/tb_prog_loader_seq.sv
// Randomized bench for prog_loader_seq against a cycle-level phase model.
module tb_prog_loader_seq;
   import prog_loader_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [4:0] prog_len = 5'd0;
   logic [7:0] run_cycles = 8'd0;
   logic       in_valid = 1'b0;
   logic [3:0] in_operand = 4'd0;
   logic [3:0] in_opcode = 4'd0;
   logic       in_ready, core_PC_reset, core_mem_write, core_hold;
   logic [3:0] core_portin, core_instr;
   logic       busy, done, err;
   logic [4:0] load_count;

   int n_chk = 0;
   int n_fail = 0;

   logic [3:0] prog_op [16];
   logic [3:0] prog_oc [16];

   prog_loader_seq #(.DATA_W(4), .DEPTH(16), .RUN_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .prog_len(prog_len), .run_cycles(run_cycles),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_operand(in_operand), .in_opcode(in_opcode),
      .core_PC_reset(core_PC_reset), .core_mem_write(core_mem_write),
      .core_hold(core_hold), .core_portin(core_portin), .core_instr(core_instr),
      .busy(busy), .done(done), .err(err), .load_count(load_count)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Observed outputs: busy,in_ready,PC_reset,mem_write,hold,done,err,portin,instr.
   function automatic logic [14:0] obs();
      return {busy, in_ready, core_PC_reset, core_mem_write, core_hold, done, err,
              core_portin, core_instr};
   endfunction

   localparam logic [14:0] E_IDLE  = {7'b0000100, 8'h00};
   localparam logic [14:0] E_PCR   = {7'b1010000, 8'h00};
   localparam logic [14:0] E_RUN   = {7'b1000000, 8'h00};
   localparam logic [14:0] E_DONE  = {7'b0000110, 8'h00};
   localparam logic [14:0] E_ERR   = {7'b0000101, 8'h00};

   task automatic set_ref_prog();
      prog_op[0] = 4'd3; prog_oc[0] = OP_LDI;
      prog_op[1] = 4'd0; prog_oc[1] = OP_ADD;
      prog_op[2] = 4'd3; prog_oc[2] = OP_LDI;
      prog_op[3] = 4'd1; prog_oc[3] = OP_ADD;
      prog_op[4] = 4'd0; prog_oc[4] = OP_SUB;
      prog_op[5] = 4'd0; prog_oc[5] = OP_JMP;
      prog_op[6] = 4'd1; prog_oc[6] = OP_SUB;
      prog_op[7] = 4'd0; prog_oc[7] = OP_NOP;
      prog_op[8] = 4'd0; prog_oc[8] = OP_OUT;
      prog_op[9] = 4'd9; prog_oc[9] = OP_HALT;
   endtask

   // Full job: start, PC reset, load (mode 0 continuous, 1 alternate, 2 random
   // valid), rewind, run for max(rc,1) cycles, done pulse.
   task automatic do_program(input int len, input int rc, input int mode,
                             input bit start_in_load, input string tag);
      int acc, cyc, nrun;
      bit v;
      logic [14:0] e;
      nrun = (rc == 0) ? 1 : rc;
      @(posedge clk); #1;
      start = 1'b1; prog_len = 5'(len); run_cycles = 8'(rc);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      n_chk++;
      if (obs() !== E_PCR) begin
         n_fail++; $display("FAIL %s pcrst: got %h want %h", tag, obs(), E_PCR);
      end
      @(posedge clk); #1;
      acc = 0; cyc = 0;
      while (acc < len && cyc < 400) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         in_valid   = v;
         in_operand = v ? prog_op[acc] : 4'($urandom);
         in_opcode  = v ? prog_oc[acc] : 4'($urandom);
         start      = start_in_load && (cyc == 1);
         if (start) prog_len = 5'd0;
         @(negedge clk);
         e = {1'b1, 1'b1, 1'b0, v, !v, 1'b0, 1'b0, in_operand, in_opcode};
         n_chk++;
         if (obs() !== e) begin
            n_fail++; $display("FAIL %s load cyc %0d: got %h want %h", tag, cyc, obs(), e);
         end
         n_chk++;
         if (load_count !== 5'(acc)) begin
            n_fail++; $display("FAIL %s load_count cyc %0d: got %0d want %0d", tag, cyc, load_count, acc);
         end
         if (v) acc++;
         cyc++;
         @(posedge clk); #1;
      end
      n_chk++;
      if (acc < len) begin
         n_fail++; $display("FAIL %s load timeout: got %0d want %0d words", tag, acc, len);
      end
      in_valid = 1'b0; start = 1'b0; in_operand = 4'd0; in_opcode = 4'd0;
      @(negedge clk);
      n_chk++;
      if (obs() !== E_PCR || load_count !== 5'(len)) begin
         n_fail++; $display("FAIL %s rewind: got %h/%0d want %h/%0d", tag, obs(), load_count, E_PCR, len);
      end
      @(posedge clk); #1;
      for (int i = 0; i < nrun; i++) begin
         @(negedge clk);
         n_chk++;
         if (obs() !== E_RUN) begin
            n_fail++; $display("FAIL %s run cyc %0d: got %h want %h", tag, i, obs(), E_RUN);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_chk++;
      if (obs() !== E_DONE) begin
         n_fail++; $display("FAIL %s done: got %h want %h", tag, obs(), E_DONE);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_chk++;
      if (obs() !== E_IDLE) begin
         n_fail++; $display("FAIL %s after done: got %h want %h", tag, obs(), E_IDLE);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #12;
      n_chk++;
      if (obs() !== E_IDLE || load_count !== 5'd0) begin
         n_fail++; $display("FAIL reset: got %h/%0d want %h/0", obs(), load_count, E_IDLE);
      end
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (obs() !== E_IDLE) begin
         n_fail++; $display("FAIL reset release: got %h want %h", obs(), E_IDLE);
      end
   endtask

   task automatic test_reference();
      set_ref_prog();
      do_program(10, 20, 0, 1'b0, "reference");
   endtask

   task automatic test_bubbled();
      set_ref_prog();
      do_program(10, 20, 1, 1'b0, "bubbled");
   endtask

   task automatic test_illegal();
      logic [4:0] bad [3];
      bad[0] = 5'd0; bad[1] = 5'd17; bad[2] = 5'($urandom_range(18, 31));
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         start = 1'b1; prog_len = bad[k];
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         n_chk++;
         if (obs() !== E_ERR) begin
            n_fail++; $display("FAIL illegal len %0d: got %h want %h", bad[k], obs(), E_ERR);
         end
         @(posedge clk); #1;
         @(negedge clk);
         n_chk++;
         if (obs() !== E_IDLE) begin
            n_fail++; $display("FAIL illegal len %0d after: got %h want %h", bad[k], obs(), E_IDLE);
         end
      end
   endtask

   task automatic test_abort_idle();
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         start = 1'b1; abort = 1'b1; prog_len = (k == 0) ? 5'd5 : 5'd0;
         @(posedge clk); #1;
         start = 1'b0; abort = 1'b0;
         @(negedge clk);
         n_chk++;
         if (obs() !== E_IDLE) begin
            n_fail++; $display("FAIL abort_idle %0d: got %h want %h", k, obs(), E_IDLE);
         end
      end
   endtask

   task automatic test_abort_load();
      logic [14:0] e;
      for (int i = 0; i < 16; i++) begin
         prog_op[i] = 4'($urandom); prog_oc[i] = 4'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b1; prog_len = 5'd10; run_cycles = 8'd5;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;       // first iteration leaves PCRST
         if (i < 4) begin
            in_valid = 1'b1; in_operand = prog_op[i]; in_opcode = prog_oc[i];
         end
      end
      in_valid = 1'b0; in_operand = 4'd0; in_opcode = 4'd0; abort = 1'b1;
      @(negedge clk);
      e = {7'b1100100, 8'h00};
      n_chk++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL abort_load during: got %h want %h", obs(), e);
      end
      @(posedge clk); #1;
      abort = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_chk++;
         if (obs() !== E_IDLE || load_count !== 5'd4) begin
            n_fail++; $display("FAIL abort_load idle %0d: got %h/%0d want %h/4", i, obs(), load_count, E_IDLE);
         end
         @(posedge clk); #1;
      end
      do_program(10, 7, 2, 1'b0, "after_abort");
   endtask

   task automatic test_start_busy();
      for (int i = 0; i < 16; i++) begin
         prog_op[i] = 4'($urandom); prog_oc[i] = 4'($urandom);
      end
      do_program(5, 0, 0, 1'b1, "start_busy_rc0");
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         int len, rc, mode;
         len  = $urandom_range(1, 16);
         rc   = (r == 0) ? 0 : $urandom_range(0, 40);
         mode = $urandom_range(0, 2);
         for (int i = 0; i < 16; i++) begin
            prog_op[i] = 4'($urandom); prog_oc[i] = 4'($urandom);
         end
         do_program(len, rc, mode, 1'b0, "random");
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk); #1;
      start = 1'b1; prog_len = 5'd2; run_cycles = 8'd30;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_operand = 4'($urandom); in_opcode = 4'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_operand = 4'd0; in_opcode = 4'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL async_reset pre: busy got %b want 1", busy);
      end
      reset_n = 1'b0;
      #1;
      n_chk++;
      if (obs() !== E_IDLE || load_count !== 5'd0) begin
         n_fail++; $display("FAIL async_reset: got %h/%0d want %h/0", obs(), load_count, E_IDLE);
      end
      #4;
      reset_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n_chk++;
         if (obs() !== E_IDLE) begin
            n_fail++; $display("FAIL async_reset after %0d: got %h want %h", i, obs(), E_IDLE);
         end
      end
   endtask

   initial begin
      test_reset();
      test_reference();
      test_bubbled();
      test_illegal();
      test_abort_idle();
      test_abort_load();
      test_start_busy();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_loader_seq.md
Name: prog_loader_seq

Overview:
- Sequencer that owns the program-load and run phases of the 4-bit processor core (Control_Prog).
- Accepts a stream of (operand, opcode) words from a host over a valid/ready handshake and drives the core's mem_write, PC_reset, portin and instr.
- After loading, rewinds the PC, lets the core run for a programmed number of cycles, then reports done.
- Replaces hand-sequenced bench stimulus with a reusable on-chip loader.

Parameters:
- DATA_W, 4, width of operand and opcode fields.
- DEPTH, 16, maximum program words; equals the core program memory size.
- RUN_W, 8, width of the run-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin load; sampled only in IDLE.
- abort  in  1  synchronous abort; returns the block to IDLE from any state.
- prog_len  in  5  number of words to load, latched at start; legal range 1..DEPTH.
- run_cycles  in  RUN_W  core run length, latched at start; value 0 means 1 cycle.
- in_valid  in  1  host word valid.
- in_ready  out  1  loader accepts a word.
- in_operand  in  DATA_W  operand field, routed to core portin.
- in_opcode  in  DATA_W  opcode field, routed to core instr.
- core_PC_reset  out  1  core PC reset, active-high.
- core_mem_write  out  1  core program-memory write enable.
- core_hold  out  1  core PC/execution stall; the integration gates PC increment with it.
- core_portin  out  DATA_W  operand to core.
- core_instr  out  DATA_W  opcode to core.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on RUN completion.
- err  out  1  one-cycle pulse when start is rejected.
- load_count  out  5  number of words accepted in the current load.

Behaviour:
- States: IDLE, PCRST, LOAD, REWIND, RUN.
- Reset (reset_n=0, asynchronous):
  - state=IDLE, load_count=0, run counter=0, latched prog_len and run_cycles=0.
  - done=0, err=0, core_hold=1, all other outputs 0.
- IDLE:
  - core_hold=1.
  - start=1 with prog_len in 1..16: latch prog_len and run_cycles, clear load_count, go to PCRST next cycle.
  - start=1 with prog_len=0 or >16: err=1 for the next cycle; state stays IDLE.
- PCRST: exactly one cycle.
  - core_PC_reset=1, core_mem_write=0, core_hold=0.
  - Go to LOAD.
- LOAD:
  - in_ready=1.
  - core_mem_write = in_valid (combinational); core_portin=in_operand, core_instr=in_opcode (combinational pass-through).
  - core_hold = ~in_valid, so bubbles do not advance the PC.
  - On each accept (in_valid & in_ready): load_count increments.
  - When the accept takes load_count to prog_len, go to REWIND next cycle.
- REWIND: exactly one cycle.
  - core_PC_reset=1, core_mem_write=0, core_hold=0, in_ready=0.
  - Load the run counter with max(run_cycles,1); go to RUN.
- RUN:
  - core_hold=0, core_PC_reset=0, core_mem_write=0, in_ready=0.
  - Counter decrements each cycle; when it reaches 1, go to IDLE and assert done for that cycle.
  - Core runs for exactly max(run_cycles,1) cycles.
- Output defaults:
  - core_portin and core_instr are 0 outside LOAD.
  - in_ready is 0 outside LOAD.
- Abort:
  - Priority over all transitions; next state IDLE, core_hold=1, no done.
  - load_count holds its value until the next start.
- Simultaneous events:
  - start outside IDLE is ignored, with no err.
  - abort and start both in IDLE: abort wins; state stays IDLE.
  - An accept on the final LOAD cycle together with abort: the write still occurs that cycle; the next state is IDLE.
- Mid-operation reset: immediate return to the reset values. The core memory contents are undefined from the loader's view.
- Wrap-around: load_count never exceeds prog_len; no overflow is possible.
- The run counter saturates at 0 and never wraps.

Decomposition:
- Package prog_loader_pkg holds:
  - the state enum (IDLE, PCRST, LOAD, REWIND, RUN);
  - DEPTH and DATA_W constants;
  - opcode constants matching the core ISA, for bench use.
- One sub-module, run_timer: loadable down-counter with a terminal-count flag, width RUN_W.

Test Plan:
- Reference program, continuous valid: after reset, start with prog_len=10, run_cycles=20, then stream 10 words back-to-back.
  - Word list (operand,opcode): (3,6),(0,4),(3,6),(1,4),(0,5),(0,8),(1,5),(0,0),(0,7),(9,9).
  - Required: core_PC_reset high exactly 1 cycle before the first write; core_mem_write high for exactly 10 consecutive cycles; then a 1-cycle REWIND PC_reset; then 20 RUN cycles; done pulses once; busy falls with done.
- Bubbled valid: same program with in_valid low every other cycle.
  - Required: 10 writes; core_hold=1 on each bubble; load_count=10 entering REWIND.
- Illegal length: start with prog_len=0, then with prog_len=17.
  - Required: err pulses 1 cycle each time; busy stays 0; no core_PC_reset.
- Abort mid-load: abort after 4 accepted words.
  - Required: next cycle IDLE, core_hold=1, load_count=4, no done; a fresh start afterwards completes normally.
- Async reset mid-RUN: drop reset_n for half a cycle during RUN.
  - Required: outputs go to reset values immediately without waiting for a clock edge; no done.
- run_cycles=0 and start while busy:
  - run_cycles=0 gives exactly 1 RUN cycle.
  - start pulsed during LOAD is ignored, with no err.
